// File: rtl/far_pointer_loader_pkg.sv
// Shared definitions for the far-pointer loader and the segment register file:
// segment register encoding and memory bus byte-lane enables.
package far_pointer_loader_pkg;

  typedef enum logic [1:0] {
    ES = 2'd0,
    CS = 2'd1,
    SS = 2'd2,
    DS = 2'd3
  } SR_t;

  localparam logic [1:0] BYTESEL_WORD = 2'b11;
  localparam logic [1:0] BYTESEL_LO   = 2'b01;
  localparam logic [1:0] BYTESEL_HI   = 2'b10;

endpackage

// File: rtl/far_pointer_loader.sv
// LDS/LES-style far-pointer load sequencer: reads offset and segment words over the
// data bus, returns the offset and writes the segment register. FAR_POINTER_UNALIGNED_EN
// enables servicing odd addresses with three byte/word accesses instead of an error.
module far_pointer_loader
  import far_pointer_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            seg_sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           offset_val,
  output logic                  m_access,
  input  logic                  m_ack,
  output logic [ADDR_WIDTH-2:0] m_addr,
  output logic [1:0]            m_bytesel,
  input  logic [15:0]           m_data_in,
  output logic                  seg_wr_en,
  output logic [1:0]            seg_wr_sel,
  output logic [15:0]           seg_wr_val
);

`ifdef FAR_POINTER_UNALIGNED_EN
  typedef enum logic [2:0] {IDLE, RD_OFF, RD_SEG, WRITE, RD_B0, RD_MID, RD_B3} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_OFF, RD_SEG, WRITE} state_t;
`endif

  localparam logic [ADDR_WIDTH-2:0] WORD_ONE = 1;

  state_t                state, state_n;
  SR_t                   lat_sel, lat_sel_n;
  logic                  busy_n, done_n, error_n, m_access_n, seg_wr_en_n;
  logic [15:0]           offset_n, seg_wr_val_n;
  logic [ADDR_WIDTH-2:0] m_addr_n;
  logic [1:0]            m_bytesel_n, seg_wr_sel_n;
`ifdef FAR_POINTER_UNALIGNED_EN
  logic [7:0]            seg_lo, seg_lo_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_sel    <= ES;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      offset_val <= '0;
      m_access   <= 1'b0;
      m_addr     <= '0;
      m_bytesel  <= '0;
      seg_wr_en  <= 1'b0;
      seg_wr_sel <= '0;
      seg_wr_val <= '0;
`ifdef FAR_POINTER_UNALIGNED_EN
      seg_lo     <= '0;
`endif
    end else begin
      state      <= state_n;
      lat_sel    <= lat_sel_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      offset_val <= offset_n;
      m_access   <= m_access_n;
      m_addr     <= m_addr_n;
      m_bytesel  <= m_bytesel_n;
      seg_wr_en  <= seg_wr_en_n;
      seg_wr_sel <= seg_wr_sel_n;
      seg_wr_val <= seg_wr_val_n;
`ifdef FAR_POINTER_UNALIGNED_EN
      seg_lo     <= seg_lo_n;
`endif
    end
  end

  // Next-state logic produces next-cycle output values so every output is registered;
  // m_addr doubles as the latched word address and is stepped in place.
  always_comb begin
    state_n      = state;
    lat_sel_n    = lat_sel;
    busy_n       = busy;
    done_n       = 1'b0;
    error_n      = 1'b0;
    offset_n     = offset_val;
    m_access_n   = m_access;
    m_addr_n     = m_addr;
    m_bytesel_n  = m_bytesel;
    seg_wr_en_n  = 1'b0;
    seg_wr_sel_n = seg_wr_sel;
    seg_wr_val_n = seg_wr_val;
`ifdef FAR_POINTER_UNALIGNED_EN
    seg_lo_n     = seg_lo;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          lat_sel_n = SR_t'(seg_sel);
          busy_n    = 1'b1;
          m_addr_n  = addr[ADDR_WIDTH-1:1];
          if (!addr[0]) begin
            state_n     = RD_OFF;
            m_access_n  = 1'b1;
            m_bytesel_n = BYTESEL_WORD;
          end else begin
`ifdef FAR_POINTER_UNALIGNED_EN
            state_n     = RD_B0;
            m_access_n  = 1'b1;
            m_bytesel_n = BYTESEL_HI;
`else
            state_n = WRITE;
            done_n  = 1'b1;
            error_n = 1'b1;
`endif
          end
        end
      end
      RD_OFF: begin
        if (m_ack) begin
          offset_n = m_data_in;
          m_addr_n = m_addr + WORD_ONE;
          state_n  = RD_SEG;
        end
      end
      RD_SEG: begin
        if (m_ack) begin
          state_n      = WRITE;
          m_access_n   = 1'b0;
          seg_wr_en_n  = 1'b1;
          seg_wr_sel_n = lat_sel;
          seg_wr_val_n = m_data_in;
          done_n       = 1'b1;
        end
      end
      WRITE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
`ifdef FAR_POINTER_UNALIGNED_EN
      // Odd pointer: hi byte of the first word, full middle word, lo byte of the last word.
      RD_B0: begin
        if (m_ack) begin
          offset_n    = {offset_val[15:8], m_data_in[15:8]};
          m_addr_n    = m_addr + WORD_ONE;
          m_bytesel_n = BYTESEL_WORD;
          state_n     = RD_MID;
        end
      end
      RD_MID: begin
        if (m_ack) begin
          offset_n    = {m_data_in[7:0], offset_val[7:0]};
          seg_lo_n    = m_data_in[15:8];
          m_addr_n    = m_addr + WORD_ONE;
          m_bytesel_n = BYTESEL_LO;
          state_n     = RD_B3;
        end
      end
      RD_B3: begin
        if (m_ack) begin
          state_n      = WRITE;
          m_access_n   = 1'b0;
          seg_wr_en_n  = 1'b1;
          seg_wr_sel_n = lat_sel;
          seg_wr_val_n = {m_data_in[7:0], seg_lo};
          done_n       = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/far_pointer_loader.md
Name: far_pointer_loader

Overview:
- Sequencer for LDS/LES-style far-pointer loads.
- Fetches a 32-bit far pointer (offset word at addr, segment word at addr+2) over the data memory bus.
- Returns the offset to the microcode datapath.
- Drives the write port of the segment register file to load the selected segment register.
- Sits between the microcode engine and the memory bus arbiter, alongside the segment register file.

Parameters:
- ADDR_WIDTH, 20, physical address width; all address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- seg_sel  input  2  destination segment register (ES=0, CS=1, SS=2, DS=3)
- addr  input  ADDR_WIDTH  physical address of the pointer's offset word
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse, coincident with done, on a rejected request
- offset_val  output  16  loaded offset; held until the next accepted start
- m_access  output  1  memory request
- m_ack  input  1  memory acknowledge; read data valid in the same cycle
- m_addr  output  ADDR_WIDTH-1  word address (addr[ADDR_WIDTH-1:1])
- m_bytesel  output  2  byte-lane enables; 2'b11 = word
- m_data_in  input  16  read data
- seg_wr_en  output  1  segment register file write enable
- seg_wr_sel  output  2  segment register file write select
- seg_wr_val  output  16  segment register file write data

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): state = IDLE; all outputs 0; latched seg_sel/addr cleared. m_access falls without waiting for m_ack.
- All outputs are registered.
- IDLE:
  - start=1 latches seg_sel and addr.
  - Goes to RD_OFF with m_access=1, busy=1 in the next cycle.
  - start while busy is ignored.
- Bus handshake:
  - m_access, m_addr and m_bytesel are held stable until m_ack is sampled high.
  - Data is captured on the ack edge.
  - The next access may begin in the following cycle; m_access stays high across back-to-back accesses.
- RD_OFF: word read at addr; on ack, offset_val <= m_data_in; go to RD_SEG.
- RD_SEG: word read at addr+2 (mod 2^ADDR_WIDTH, so 0xFFFFE wraps to 0x00000); on ack, go to WRITE.
- WRITE (one cycle):
  - seg_wr_en=1, seg_wr_sel = latched seg_sel, seg_wr_val = segment word; done=1, m_access=0.
  - Next state IDLE with busy=0.
- Latency with zero-wait memory: start at edge N → accesses in cycles N+1 and N+2 → seg_wr_en/done in cycle N+3. Each wait state adds one cycle.
- Odd addr:
  - Behaviour depends on the optional feature below.
  - Without the feature: no bus access is made. Goes directly to WRITE with seg_wr_en=0, done=1, error=1; offset_val is unchanged.
- Writes with seg_sel=CS are not special-cased; the segment register file's bypass handles same-cycle readers.

Optional Feature:
- Macro: FAR_POINTER_UNALIGNED_EN.
- When defined, odd addr is serviced with three accesses:
  - byte read at addr, lane hi (m_bytesel=2'b10) → offset[7:0];
  - word read at addr+1 (even) → offset[15:8] = data[7:0], segment[7:0] = data[15:8];
  - byte read at addr+3, lane lo (m_bytesel=2'b01) → segment[15:8].
- States: RD_B0, RD_MID, RD_B3, then WRITE. Same wrap rules apply; error is never asserted.
- When undefined: the odd-address error path applies, and these states and their logic are absent.

Decomposition:
- Shared package (also used by the segment register file):
  - segment enum SR_t (ES, CS, SS, DS);
  - byte-select constants BYTESEL_WORD/LO/HI.
- Local to the module: state enum.
- No sub-module is needed; the address incrementer is inline.

Test Plan:
- Aligned, zero-wait: addr=0x01230, seg_sel=DS, mem[0x01230]=0x5678, mem[0x01232]=0x9ABC → cycle N+3: seg_wr_en=1, seg_wr_sel=3, seg_wr_val=0x9ABC, offset_val=0x5678, done=1.
- Wait states: m_ack delayed 2 cycles per access → m_addr/m_access held stable while waiting; done at N+7; identical values.
- Wrap: addr=0xFFFFE → second access m_addr=0x00000; segment word taken from physical 0x00000.
- Odd addr=0x00101:
  - macro off → done=error=1 at N+1, no m_access, seg_wr_en=0;
  - macro on → bytesel sequence 10, 11, 01 at word addresses 0x080, 0x081, 0x082; correct byte assembly; error=0.
- Reset mid-op: assert reset during RD_SEG before ack → m_access=0, busy=0, no seg_wr_en; a fresh start after release completes normally.
- start pulsed while busy and back-to-back starts → the second is ignored while busy; one accepted immediately after done completes.
